bram_burst_rd: RTL and testbench
================================

// Module: bram_burst_rd
// PURPOSE
//   Parametrised burst reader for a native-port block RAM. On a start pulse it reads rd_len
//   consecutive words from start_addr, stepping the address by ADDR_STEP, and absorbs the
//   RAM read latency. Data is delivered on a valid/ready stream, buffered by an internal
//   credit-managed FIFO. Sits between the PS-written base-address register and the
//   datapath that consumes feature/weight words from BRAM.
// PARAMETERS
//   ADDR_W      32  width of start_addr / ram_addr
//   DATA_W      32  width of ram_rd_data / dout
//   LEN_W       16  width of rd_len (words per burst)
//   ADDR_STEP   4   ram_addr increment per word (bytes)
//   RD_LAT      1   cycles from ram_en to valid ram_rd_data (>=1)
//   FIFO_DEPTH  4   output buffer entries; >= RD_LAT+2 for 1 word/cycle throughput
// PORTS
//   clk          in   1       system clock
//   rst_n        in   1       async active-low reset
//   start        in   1       1-cycle burst request; sampled only in IDLE
//   start_addr   in   ADDR_W  first word address
//   rd_len       in   LEN_W   words to read; 0 = empty burst
//   busy         out  1       high from accepted start until done
//   done         out  1       1-cycle pulse at burst completion
//   ram_clk      out  1       = clk
//   ram_rst      out  1       constant 0
//   ram_en       out  1       registered read strobe, high only on issue cycles
//   ram_addr     out  ADDR_W  registered read address
//   ram_rd_data  in   DATA_W  RAM read data, valid RD_LAT cycles after ram_en
//   dout         out  DATA_W  FIFO head word
//   dout_valid   out  1       FIFO non-empty
//   dout_ready   in   1       consumer accepts dout when dout_valid & dout_ready
// BEHAVIOUR
//   Reset (async): state=IDLE; busy=0, done=0, ram_en=0, ram_addr=0, dout_valid=0, dout=0.
//     FIFO, pipeline and counters are cleared, and in-flight reads are discarded.
//   FSM IDLE -> READ: start=1 and rd_len!=0. Latch start_addr into the address counter
//     and rd_len into the issue counter; busy=1 from the next cycle.
//   IDLE, start=1, rd_len=0: done=1 in the next cycle, busy stays 0, and ram_en is never set.
//   READ: issue when outstanding + fifo_count < FIFO_DEPTH. Outstanding counts issued reads
//     whose data has not yet been written to the FIFO. An issue sets ram_en=1 with
//     ram_addr=current address on the next edge, then the address advances by ADDR_STEP.
//     Address arithmetic wraps modulo 2^ADDR_W. When no issue occurs, ram_en=0 and ram_addr holds.
//   READ -> DRAIN: after the last (rd_len-th) issue.
//   DRAIN -> IDLE: outstanding=0, FIFO empty, and no handshake pending. done=1 for one
//     cycle, coinciding with busy falling to 0.
//   Return path: an RD_LAT-deep valid shift register tracks ram_en. On its tap, ram_rd_data
//     is written to the FIFO tail.
//   Latency with RD_LAT=1 and dout_ready=1: start at T0, ram_en at T1, data at T2,
//     dout_valid at T3. Throughput is 1 word/cycle.
//   Push and pop in the same cycle leave the FIFO count unchanged. The credit rule makes
//     overflow impossible; underflow cannot occur because pop requires dout_valid.
//   dout and dout_valid are stable while dout_valid=1 and dout_ready=0.
//   start is ignored in READ and DRAIN, and a later start is never queued.
//   The next start is accepted in the same cycle done is asserted only if state=IDLE,
//     i.e. from the following cycle.
// TESTING
//   1 Basic: RAM model returns data=addr; start_addr=0x100, rd_len=4, ready=1 -> dout
//     0x100,0x104,0x108,0x10C on 4 consecutive cycles; first dout_valid 3 cycles after
//     start; done pulses once.
//   2 Backpressure: rd_len=16, ready=0 for 10 cycles mid-burst -> ram_en stops once
//     outstanding+fifo=FIFO_DEPTH; all 16 words delivered in order, no drop or duplicate.
//   3 Empty burst: rd_len=0 -> done in the next cycle, busy=0 and ram_en=0 throughout.
//   4 Wrap: start_addr=0xFFFFFFF8, rd_len=4 -> ram_addr 0xFFFFFFF8,0xFFFFFFFC,0x0,0x4.
//   5 Start while busy ignored; rst_n low mid-burst -> all outputs at reset values at once;
//     a new burst of 2 words after release returns exactly 2 correct words.
//   6 RD_LAT=3, FIFO_DEPTH=5: rd_len=8, ready=1 -> 1 word/cycle, first dout_valid 5 cycles
//     after start.

Source files
------------

// File: rtl/bram_burst_rd_if.sv
// Burst-reader bundle: start/status, native BRAM read port and output stream.
// The master modport is the reader; the slave modport is its environment.
interface bram_burst_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              busy;
  logic              done;
  logic              ram_clk;
  logic              ram_rst;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    input  start, start_addr, rd_len,
    input  ram_rd_data, dout_ready,
    output busy, done,
    output ram_clk, ram_rst, ram_en, ram_addr,
    output dout, dout_valid
  );

  modport slave (
    output start, start_addr, rd_len,
    output ram_rd_data, dout_ready,
    input  busy, done,
    input  ram_clk, ram_rst, ram_en, ram_addr,
    input  dout, dout_valid
  );
endinterface

// File: rtl/bram_burst_rd.sv
// Burst reader for a native-port BRAM with latency absorption
// and a credit-managed output FIFO.
module bram_burst_rd #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int ADDR_STEP  = 4,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  bram_burst_rd_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [RD_LAT-1:0] vld_sr;
  logic              ram_en;
  logic              busy;
  logic              done;

  logic             push;
  logic             pop;
  logic             valid;
  logic             credit;
  logic             issue;
  logic             first;
  logic             en_next;
  logic [CNT_W:0]   inflight;
  logic [CNT_W:0]   limit;

  assign valid    = (fifo_count != '0);
  assign push     = vld_sr[RD_LAT-1];
  assign pop      = valid & bus.dout_ready;
  // A pop this cycle frees a slot in time for the word issued now.
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign limit    = (CNT_W+1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop};
  assign credit   = (inflight < limit);
  assign issue    = (state == READ) & credit;
  assign first    = (state == IDLE) & bus.start & (bus.rd_len != '0);
  assign en_next  = issue | first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      ram_addr  <= '0;
      remaining <= '0;
      ram_en    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ram_en <= en_next;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (first) begin
            ram_addr  <= bus.start_addr;
            addr      <= bus.start_addr + STEP;
            remaining <= bus.rd_len - 1'b1;
            busy      <= 1'b1;
            state     <= (bus.rd_len == LEN_W'(1)) ? DRAIN : READ;
          end else if (bus.start) begin
            done <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            ram_addr  <= addr;
            addr      <= addr + STEP;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0 && fifo_count == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr      <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      vld_sr      <= RD_LAT'({vld_sr, ram_en});
      outstanding <= outstanding + CNT_W'(en_next) - CNT_W'(push);
      fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
        mem[wr_ptr] <= bus.ram_rd_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.ram_clk    = clk;
  assign bus.ram_rst    = 1'b0;
  assign bus.ram_en     = ram_en;
  assign bus.ram_addr   = ram_addr;
  assign bus.dout       = mem[rd_ptr];
  assign bus.dout_valid = valid;

endmodule

// File: tb/tb_bram_burst_rd.sv
// Bench for bram_burst_rd: data=addr RAM models, queue scoreboard
// per instance, and directed bursts with literal expectations.
module tb_bram_burst_rd;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bram_burst_rd_if ifa ();
  bram_burst_rd_if ifb ();

  bram_burst_rd dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master)
  );
  bram_burst_rd #(.RD_LAT(3), .FIFO_DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master)
  );

  logic [31:0] ram_a;
  logic [31:0] ram_b [3];
  always @(posedge clk) begin
    ram_a    <= ifa.ram_addr;
    ram_b[0] <= ifb.ram_addr;
    ram_b[1] <= ram_b[0];
    ram_b[2] <= ram_b[1];
  end
  assign ifa.ram_rd_data = ram_a;
  assign ifb.ram_rd_data = ram_b[2];

  int checks = 0;
  int errors = 0;
  logic [31:0] iss_qa[$], out_qa[$], iss_qb[$], out_qb[$];
  int issued_a = 0, popped_a = 0, done_a = 0;
  int issued_b = 0, popped_b = 0, done_b = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [31:0] held_a, held_b;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required nothing", name, act);
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) stall_a = 1'b0;
    else begin
      if (ifa.ram_en) begin
        issued_a++;
        if (iss_qa.size() == 0) note_fail("a_extra_issue", ifa.ram_addr);
        else check("a_issue_addr", ifa.ram_addr, iss_qa.pop_front());
      end
      check_le("a_credit", issued_a - popped_a, 4);
      if (stall_a) begin
        check("a_hold_valid", 32'(ifa.dout_valid), 1);
        check("a_hold_data", ifa.dout, held_a);
      end
      if (ifa.dout_valid && ifa.dout_ready) begin
        popped_a++;
        if (out_qa.size() == 0) note_fail("a_extra_dout", ifa.dout);
        else check("a_dout", ifa.dout, out_qa.pop_front());
      end
      stall_a = ifa.dout_valid && !ifa.dout_ready;
      held_a  = ifa.dout;
      if (ifa.done) begin
        done_a++;
        check("a_done_busy", 32'(ifa.busy), 0);
        check("a_done_left", 32'(out_qa.size() + iss_qa.size()), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) stall_b = 1'b0;
    else begin
      if (ifb.ram_en) begin
        issued_b++;
        if (iss_qb.size() == 0) note_fail("b_extra_issue", ifb.ram_addr);
        else check("b_issue_addr", ifb.ram_addr, iss_qb.pop_front());
      end
      check_le("b_credit", issued_b - popped_b, 5);
      if (stall_b) begin
        check("b_hold_valid", 32'(ifb.dout_valid), 1);
        check("b_hold_data", ifb.dout, held_b);
      end
      if (ifb.dout_valid && ifb.dout_ready) begin
        popped_b++;
        if (out_qb.size() == 0) note_fail("b_extra_dout", ifb.dout);
        else check("b_dout", ifb.dout, out_qb.pop_front());
      end
      stall_b = ifb.dout_valid && !ifb.dout_ready;
      held_b  = ifb.dout;
      if (ifb.done) begin
        done_b++;
        check("b_done_busy", 32'(ifb.busy), 0);
        check("b_done_left", 32'(out_qb.size() + iss_qb.size()), 0);
      end
    end
  end

  task automatic start_a(input logic [31:0] addr, input logic [15:0] len,
                         input bit accept);
    @(posedge clk); #1;
    ifa.start = 1'b1;
    ifa.start_addr = addr;
    ifa.rd_len = len;
    if (accept)
      for (int i = 0; i < int'(len); i++) begin
        iss_qa.push_back(addr + 32'(i) * 4);
        out_qa.push_back(addr + 32'(i) * 4);
      end
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (ifa.done) seen = 1;
    end
    check(name, 32'(seen), 1);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, 32'(ifa.busy), 0);
    check({tag, "_done"}, 32'(ifa.done), 0);
    check({tag, "_ram_en"}, 32'(ifa.ram_en), 0);
    check({tag, "_ram_addr"}, ifa.ram_addr, 0);
    check({tag, "_valid"}, 32'(ifa.dout_valid), 0);
    check({tag, "_dout"}, ifa.dout, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, p0;
    logic [31:0] seen_addr [4];
    ifa.start = 0; ifa.start_addr = 0; ifa.rd_len = 0; ifa.dout_ready = 1;
    ifb.start = 0; ifb.start_addr = 0; ifb.rd_len = 0; ifb.dout_ready = 1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset_a("reset");
    check("reset_b_valid", 32'(ifb.dout_valid), 0);
    @(negedge clk) rst_n = 1'b1;

    // basic burst: latency 3, then four back-to-back words
    d0 = done_a;
    start_a(32'h100, 16'd4, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n++;
      if (ifa.dout_valid) break;
    end
    check("t1_latency", 32'(n), 3);
    check("t1_w0", ifa.dout, 32'h100);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("t1_wvalid", 32'(ifa.dout_valid), 1);
      check("t1_wdata", ifa.dout, 32'h100 + 32'(k) * 4);
    end
    wait_done_a("t1_done", 30);
    repeat (3) @(negedge clk);
    #1 check("t1_done_once", 32'(done_a - d0), 1);

    // backpressure mid-burst
    p0 = popped_a;
    start_a(32'h2000, 16'd16, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 ifa.dout_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (k == 7) begin
        check("t2_en_stopped", 32'(ifa.ram_en), 0);
        check("t2_inflight", 32'(issued_a - popped_a), 4);
      end
    end
    @(posedge clk); #1 ifa.dout_ready = 1'b1;
    wait_done_a("t2_done", 100);
    @(negedge clk); #1;
    check("t2_count", 32'(popped_a - p0), 16);

    // empty burst
    d0 = done_a;
    start_a(32'h3000, 16'd0, 0);
    @(negedge clk);
    check("t3_done", 32'(ifa.done), 1);
    check("t3_busy", 32'(ifa.busy), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_busy_low", 32'(ifa.busy), 0);
    end
    #1 check("t3_done_once", 32'(done_a - d0), 1);

    // address wrap
    start_a(32'hFFFF_FFF8, 16'd4, 1);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      @(negedge clk);
      if (ifa.ram_en) begin seen_addr[n] = ifa.ram_addr; n++; end
    end
    check("t4_a0", seen_addr[0], 32'hFFFF_FFF8);
    check("t4_a1", seen_addr[1], 32'hFFFF_FFFC);
    check("t4_a2", seen_addr[2], 32'h0000_0000);
    check("t4_a3", seen_addr[3], 32'h0000_0004);
    wait_done_a("t4_done", 30);

    // start while busy, then reset mid-burst
    start_a(32'h300, 16'd8, 1);
    start_a(32'h900, 16'd3, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_reset_a("t5_rst");
    iss_qa.delete(); out_qa.delete();
    issued_a = 0; popped_a = 0;
    iss_qb.delete(); out_qb.delete();
    issued_b = 0; popped_b = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = popped_a;
    start_a(32'h400, 16'd2, 1);
    wait_done_a("t5_done", 30);
    @(negedge clk); #1;
    check("t5_count", 32'(popped_a - p0), 2);

    // RD_LAT=3, FIFO_DEPTH=5 instance
    @(posedge clk); #1;
    ifb.start = 1'b1; ifb.start_addr = 32'h500; ifb.rd_len = 16'd8;
    for (int i = 0; i < 8; i++) begin
      iss_qb.push_back(32'h500 + 32'(i) * 4);
      out_qb.push_back(32'h500 + 32'(i) * 4);
    end
    @(posedge clk); #1 ifb.start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); n++;
      if (ifb.dout_valid) break;
    end
    check("t6_latency", 32'(n), 5);
    check("t6_w0", ifb.dout, 32'h500);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check("t6_wvalid", 32'(ifb.dout_valid), 1);
      check("t6_wdata", ifb.dout, 32'h500 + 32'(k) * 4);
    end
    n = 0;
    for (int i = 0; i < 30 && n == 0; i++) begin
      @(negedge clk);
      if (ifb.done) n = 1;
    end
    check("t6_done", 32'(n), 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
